// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronises and de-glitches SCL/SDA, decodes
// START/RESTART/STOP and address/data bytes, and queues events in a FWFT FIFO.
module i2c_bus_monitor #(
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scl_i,
  input  logic                          sda_i,
  input  logic                          en_i,
  input  logic                          rd_i,
  input  logic                          clr_ovf_i,
  output logic [11:0]                   evt_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          ovf_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] EV_START   = 3'd0;
  localparam logic [2:0] EV_RESTART = 3'd1;
  localparam logic [2:0] EV_STOP    = 3'd2;
  localparam logic [2:0] EV_ADDR    = 3'd3;
  localparam logic [2:0] EV_DATA    = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_BITS, ST_ACK} state_t;

  // Index 0 is SCL, index 1 is SDA throughout the input path.
  logic [1:0]    sync1, sync2, filt, prev;
  logic [CW-1:0] flt_cnt [2];

  // A line follows its synchronised value only after FILTER_LEN cycles of disagreement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      filt  <= 2'b11;
      prev  <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1 <= {sda_i, scl_i};
      sync2 <= sync1;
      prev  <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(FILTER_LEN)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl, sda, scl_p, sda_p;
  logic start_c, stop_c, rise_c;

  assign scl   = filt[0];
  assign sda   = filt[1];
  assign scl_p = prev[0];
  assign sda_p = prev[1];

  assign start_c = scl & scl_p & sda_p & ~sda;
  assign stop_c  = scl & scl_p & ~sda_p & sda;
  assign rise_c  = scl & ~scl_p;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        first;
  logic        busy;
  logic        push;
  logic [11:0] push_evt;

  always_comb begin
    push     = 1'b0;
    push_evt = '0;
    if (en_i) begin
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            push     = 1'b1;
            push_evt = {EV_START, 1'b0, 8'h00};
          end
        end
        default: begin
          if (start_c) begin
            push     = 1'b1;
            push_evt = {EV_RESTART, 1'b0, 8'h00};
          end else if (stop_c) begin
            push     = 1'b1;
            push_evt = {EV_STOP, 1'b0, 8'h00};
          end else if (state == ST_ACK && rise_c) begin
            push     = 1'b1;
            push_evt = {(first ? EV_ADDR : EV_DATA), ~sda, shreg};
          end
        end
      endcase
    end
  end

  // Byte decoder; START/STOP abandon any partially shifted byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      first   <= 1'b0;
    end else if (!en_i) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            busy    <= 1'b1;
            bit_cnt <= '0;
            first   <= 1'b1;
            state   <= ST_BITS;
          end
        end
        ST_BITS, ST_ACK: begin
          if (start_c) begin
            bit_cnt <= '0;
            first   <= 1'b1;
            state   <= ST_BITS;
          end else if (stop_c) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rise_c) begin
            if (state == ST_BITS) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_ACK;
            end else begin
              first <= 1'b0;
              state <= ST_BITS;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = busy;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          ovf;
  logic          do_rd, do_wr, drop;

  assign empty_o = (count == '0);
  assign full_o  = (count == LW'(FIFO_DEPTH));
  assign do_rd   = rd_i & ~empty_o;
  assign do_wr   = push & (~full_o | rd_i);
  assign drop    = push & full_o & ~rd_i;

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= push_evt;
  end

  // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)           ovf <= 1'b1;
      else if (clr_ovf_i) ovf <= 1'b0;
    end
  end

  assign evt_o   = empty_o ? 12'h000 : mem[rd_ptr];
  assign level_o = count;
  assign ovf_o   = ovf;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: drives I2C transactions on the raw
// pins and compares decoded events against a transaction-level event queue.
module tb_i2c_bus_monitor;

  localparam int FL    = 3;
  localparam int DEPTH = 8;
  localparam int HALF  = 40;
  localparam int QTR   = 20;

  logic        clk = 1'b0;
  logic        rst, scl, sda, en, rd, clr_ovf;
  logic [11:0] evt_o;
  logic        empty_o, full_o, busy_o, ovf_o;
  logic [3:0]  level_o;

  i2c_bus_monitor #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda), .en_i(en),
    .rd_i(rd), .clr_ovf_i(clr_ovf), .evt_o(evt_o), .empty_o(empty_o),
    .full_o(full_o), .level_o(level_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: what the bus protocol says should be queued.
  logic [11:0] exp_q[$];
  bit m_busy  = 0;
  bit m_first = 0;
  bit m_ovf   = 0;
  bit m_en    = 1;

  function automatic void model_push(logic [2:0] t, logic a, logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back({t, a, b});
    else m_ovf = 1;
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda = 1'b0;
    if (m_en) begin
      model_push(3'd0, 1'b0, 8'h00);
      m_busy  = 1;
      m_first = 1;
    end
    wait_clks(HALF);
  endtask

  task automatic bus_restart();
    scl = 1'b0; wait_clks(QTR);
    sda = 1'b1; wait_clks(QTR);
    scl = 1'b1; wait_clks(HALF);
    sda = 1'b0;
    if (m_busy) begin
      model_push(3'd1, 1'b0, 8'h00);
      m_first = 1;
    end
    wait_clks(HALF);
  endtask

  task automatic bus_bit(logic b);
    scl = 1'b0; wait_clks(QTR);
    sda = b;    wait_clks(QTR);
    scl = 1'b1; wait_clks(HALF);
  endtask

  task automatic bus_byte(logic [7:0] v, logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(v[i]);
    bus_bit(~ack);
    if (m_busy) begin
      model_push(m_first ? 3'd3 : 3'd4, ack, v);
      m_first = 0;
    end
  endtask

  task automatic bus_stop();
    scl = 1'b0; wait_clks(QTR);
    sda = 1'b0; wait_clks(QTR);
    scl = 1'b1; wait_clks(HALF);
    sda = 1'b1;
    if (m_busy) begin
      model_push(3'd2, 1'b0, 8'h00);
      m_busy = 0;
    end
    wait_clks(HALF);
  endtask

  // Compares occupancy and overflow, then pops every queued event in order.
  task automatic drain_fifo(string tag);
    n_cmp++;
    if (int'(level_o) !== exp_q.size()) begin
      n_err++;
      $display("[TB] FAIL %s level: got %0d want %0d", tag, level_o, exp_q.size());
    end
    n_cmp++;
    if (ovf_o !== m_ovf) begin
      n_err++;
      $display("[TB] FAIL %s ovf: got %b want %b", tag, ovf_o, m_ovf);
    end
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (empty_o !== 1'b0 || evt_o !== exp_q[0]) begin
        n_err++;
        $display("[TB] FAIL %s event: got empty=%b evt=%h want evt=%h", tag, empty_o, evt_o, exp_q[0]);
      end
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s drained_empty: got %b want 1", tag, empty_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clks(3);
    n_cmp++;
    if ({evt_o, empty_o, full_o, level_o, busy_o, ovf_o} !== {12'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_held: got evt=%h e=%b f=%b l=%0d b=%b o=%b want 000 1 0 0 0 0",
               evt_o, empty_o, full_o, level_o, busy_o, ovf_o);
    end
    rst = 1'b0; wait_clks(20);
    n_cmp++;
    if ({evt_o, empty_o, full_o, level_o, busy_o, ovf_o} !== {12'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_released: got evt=%h e=%b f=%b l=%0d b=%b o=%b want 000 1 0 0 0 0",
               evt_o, empty_o, full_o, level_o, busy_o, ovf_o);
    end
  endtask

  task automatic test_basic();
    bus_start();
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL basic_busy_start: got %b want 1", busy_o);
    end
    bus_byte(8'hFA, 1'b1);
    bus_byte(8'h0C, 1'b1);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL basic_busy_mid: got %b want 1", busy_o);
    end
    bus_stop();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL basic_busy_stop: got %b want 0", busy_o);
    end
    drain_fifo("basic");
  endtask

  // The START lands exactly 3+FL edges after the first edge sampling the SDA fall.
  task automatic test_latency();
    sda = 1'b0;
    for (int n = 1; n <= 4 + FL; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 3 + FL) begin
        n_cmp++;
        if (empty_o !== 1'b1 || busy_o !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL latency_early: got empty=%b busy=%b want 1 0", empty_o, busy_o);
        end
      end
      if (n == 4 + FL) begin
        n_cmp++;
        if (empty_o !== 1'b0 || busy_o !== 1'b1 || evt_o !== 12'h000 || level_o !== 4'd1) begin
          n_err++;
          $display("[TB] FAIL latency_on_time: got empty=%b busy=%b evt=%h level=%0d want 0 1 000 1",
                   empty_o, busy_o, evt_o, level_o);
        end
      end
    end
    model_push(3'd0, 1'b0, 8'h00);
    m_busy = 1; m_first = 1;
    wait_clks(HALF);
    bus_byte(8'($urandom), 1'($urandom));
    bus_stop();
    drain_fifo("latency");
  endtask

  task automatic test_restart();
    bus_start();
    bus_byte(8'hFA, 1'($urandom));
    bus_restart();
    bus_byte(8'h15, 1'($urandom));
    bus_byte(8'h16, 1'($urandom));
    bus_stop();
    drain_fifo("restart");
  endtask

  task automatic test_nack();
    bus_start();
    bus_byte(8'h5A, 1'b0);
    bus_stop();
    drain_fifo("nack");
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 4; k++) begin
      sda = 1'b0; wait_clks(int'($urandom_range(FL - 1, 1)));
      sda = 1'b1; wait_clks(30);
    end
    n_cmp++;
    if (empty_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL glitch_suppressed: got empty=%b busy=%b want 1 0", empty_o, busy_o);
    end
    sda = 1'b0; wait_clks(FL + 1);
    model_push(3'd0, 1'b0, 8'h00);
    sda = 1'b1; wait_clks(30);
    model_push(3'd2, 1'b0, 8'h00);
    drain_fifo("glitch_long");
  endtask

  task automatic test_overflow();
    bus_start();
    for (int i = 0; i < 8; i++) bus_byte(8'($urandom), 1'($urandom));
    bus_stop();
    n_cmp++;
    if (full_o !== 1'b1 || level_o !== 4'd8 || ovf_o !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL overflow_flags: got full=%b level=%0d ovf=%b want 1 8 1", full_o, level_o, ovf_o);
    end
    drain_fifo("overflow");
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    m_ovf = 0;
    n_cmp++;
    if (ovf_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL overflow_clear: got %b want 0", ovf_o);
    end
  endtask

  // Pop timed onto the STOP push edge while full: push must still be accepted.
  task automatic test_full_pop();
    bus_start();
    for (int i = 0; i < 7; i++) bus_byte(8'($urandom), 1'($urandom));
    n_cmp++;
    if (full_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL fullpop_full: got %b want 1", full_o);
    end
    scl = 1'b0; wait_clks(QTR);
    sda = 1'b0; wait_clks(QTR);
    scl = 1'b1; wait_clks(HALF);
    sda = 1'b1;
    for (int n = 1; n <= 3 + FL; n++) begin
      @(posedge clk); @(negedge clk);
    end
    rd = 1'b1;
    @(posedge clk); @(negedge clk);
    rd = 1'b0;
    void'(exp_q.pop_front());
    model_push(3'd2, 1'b0, 8'h00);
    m_busy = 0;
    wait_clks(HALF);
    drain_fifo("full_pop");
  endtask

  task automatic test_enable();
    en = 1'b0; m_en = 0;
    bus_start();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL disabled_busy: got %b want 0", busy_o);
    end
    bus_byte(8'($urandom), 1'($urandom));
    bus_stop();
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL disabled_empty: got %b want 1", empty_o);
    end
    en = 1'b1; m_en = 1;
    wait_clks(10);
    bus_start();
    bus_byte(8'($urandom), 1'($urandom));
    bus_stop();
    drain_fifo("reenabled");
  endtask

  task automatic test_reset_midtransfer();
    logic [7:0] v;
    v = 8'($urandom);
    bus_start();
    bus_byte(8'($urandom), 1'b1);
    for (int i = 7; i >= 5; i--) bus_bit(v[i]);
    scl = 1'b0; wait_clks(5);
    rst = 1'b1; wait_clks(2);
    n_cmp++;
    if ({evt_o, empty_o, full_o, level_o, busy_o, ovf_o} !== {12'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL midreset_outputs: got evt=%h e=%b f=%b l=%0d b=%b o=%b want 000 1 0 0 0 0",
               evt_o, empty_o, full_o, level_o, busy_o, ovf_o);
    end
    rst = 1'b0;
    exp_q.delete();
    m_busy = 0; m_ovf = 0;
    wait_clks(QTR - 7);
    sda = v[4]; wait_clks(QTR);
    scl = 1'b1; wait_clks(HALF);
    for (int i = 3; i >= 0; i--) bus_bit(v[i]);
    bus_bit(1'b0);
    n_cmp++;
    if (empty_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midreset_ignored: got empty=%b busy=%b want 1 0", empty_o, busy_o);
    end
    bus_stop();
    bus_start();
    bus_byte(8'($urandom), 1'($urandom));
    bus_stop();
    drain_fifo("after_reset");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      bus_start();
      repeat (int'($urandom_range(2, 1))) bus_byte(8'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        bus_restart();
        repeat (int'($urandom_range(2, 1))) bus_byte(8'($urandom), 1'($urandom));
      end
      bus_stop();
      drain_fifo("back_to_back");
    end
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda = 1'b1; en = 1'b1; rd = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_latency();
    test_restart();
    test_nack();
    test_glitch();
    test_overflow();
    test_full_pop();
    test_enable();
    test_reset_midtransfer();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
